// File: rtl/ysyx_24120013_exu_seq.sv
// Multi-cycle NPC sequencer: owns the PC and steps FETCH/DECODE/EXEC/WB,
// latching the instruction and gating the EXU write into one WB strobe.
module ysyx_24120013_exu_seq #(
  parameter int unsigned     ADDR_WIDTH    = 5,
  parameter int unsigned     DATA_WIDTH    = 32,
  parameter logic [31:0]     RESET_PC      = 32'h8000_0000,
  parameter int unsigned     FETCH_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req,
  output logic [31:0]           ifu_pc,
  input  logic                  ifu_rvalid,
  input  logic [31:0]           ifu_inst,
  output logic [31:0]           inst,
  input  logic                  is_ebreak,
  input  logic                  jump_valid,
  input  logic [31:0]           jump_target,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_waddr,
  input  logic [DATA_WIDTH-1:0] exu_wdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  halt,
  output logic                  err,
  output logic [31:0]           retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [7:0]  cnt;
  logic        wen_q;

  assign ifu_pc  = pc;
  assign ifu_req = (state == S_FETCH);
  assign rf_wen  = (state == S_WB) && wen_q;
  assign halt    = (state == S_HALT);
  assign err     = (state == S_ERROR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      next_pc  <= RESET_PC;
      inst     <= '0;
      cnt      <= '0;
      wen_q    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      retired  <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          // rvalid on the final allowed cycle still wins over timeout
          if (ifu_rvalid) begin
            inst  <= ifu_inst;
            cnt   <= '0;
            state <= S_DECODE;
          end else if (cnt == TO_LAST) begin
            state <= S_ERROR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (is_ebreak) begin
            state <= S_HALT;
          end else if (jump_valid && (jump_target[1:0] != 2'b00)) begin
            state <= S_ERROR;
          end else begin
            wen_q    <= exu_wen && (exu_waddr != '0);
            rf_waddr <= exu_waddr;
            rf_wdata <= exu_wdata;
            next_pc  <= jump_valid ? jump_target : pc + 32'd4;
            state    <= S_WB;
          end
        end
        S_WB: begin
          pc      <= next_pc;
          retired <= retired + 32'd1;
          wen_q   <= 1'b0;
          state   <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        S_ERROR: state <= S_ERROR;
        default: state <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24120013_exu_seq.sv
// Directed bench for the NPC sequencer: each step waits one edge,
// then checks outputs 1ns later against hand-computed values.
module tb_ysyx_24120013_exu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req;
  logic [31:0] ifu_pc;
  logic        ifu_rvalid;
  logic [31:0] ifu_inst;
  logic [31:0] inst;
  logic        is_ebreak;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        exu_wen;
  logic [4:0]  exu_waddr;
  logic [31:0] exu_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        halt;
  logic        err;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_24120013_exu_seq dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_req    (ifu_req),
    .ifu_pc     (ifu_pc),
    .ifu_rvalid (ifu_rvalid),
    .ifu_inst   (ifu_inst),
    .inst       (inst),
    .is_ebreak  (is_ebreak),
    .jump_valid (jump_valid),
    .jump_target(jump_target),
    .exu_wen    (exu_wen),
    .exu_waddr  (exu_waddr),
    .exu_wdata  (exu_wdata),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .halt       (halt),
    .err        (err),
    .retired    (retired)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    ifu_rvalid  = 1'b0;
    ifu_inst    = '0;
    is_ebreak   = 1'b0;
    jump_valid  = 1'b0;
    jump_target = '0;
    exu_wen     = 1'b0;
    exu_waddr   = '0;
    exu_wdata   = '0;
    do_reset();

    // reset state
    check("rst_pc", ifu_pc, 32'h8000_0000);
    check("rst_req", {31'd0, ifu_req}, 32'd1);
    check("rst_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ret", retired, 32'd0);
    check("rst_inst", inst, 32'd0);

    // 1: addi x1,x0,5 with rvalid every cycle
    ifu_rvalid = 1'b1;
    ifu_inst   = 32'h0050_0093;
    exu_wen    = 1'b1;
    exu_waddr  = 5'd1;
    exu_wdata  = 32'd5;
    step();
    check("t1_inst", inst, 32'h0050_0093);
    check("t1_req_dec", {31'd0, ifu_req}, 32'd0);
    step();
    check("t1_wen_exec", {31'd0, rf_wen}, 32'd0);
    step();
    check("t1_wen_wb", {31'd0, rf_wen}, 32'd1);
    check("t1_waddr", {27'd0, rf_waddr}, 32'd1);
    check("t1_wdata", rf_wdata, 32'd5);
    step();
    check("t1_pc", ifu_pc, 32'h8000_0004);
    check("t1_ret", retired, 32'd1);
    check("t1_wen_off", {31'd0, rf_wen}, 32'd0);

    // 2: rvalid delayed 3 cycles
    ifu_rvalid = 1'b0;
    ifu_inst   = 32'h00A0_0113;
    exu_waddr  = 5'd2;
    exu_wdata  = 32'd10;
    for (int i = 0; i < 3; i++) begin
      check("t2_req_wait", {31'd0, ifu_req}, 32'd1);
      step();
    end
    check("t2_req_4th", {31'd0, ifu_req}, 32'd1);
    ifu_rvalid = 1'b1;
    step();
    check("t2_inst", inst, 32'h00A0_0113);
    check("t2_err", {31'd0, err}, 32'd0);
    step(2);
    check("t2_wen_wb", {31'd0, rf_wen}, 32'd1);
    check("t2_waddr", {27'd0, rf_waddr}, 32'd2);
    check("t2_wdata", rf_wdata, 32'd10);
    step();
    check("t2_pc", ifu_pc, 32'h8000_0008);
    check("t2_ret", retired, 32'd2);

    // 3a: rvalid exactly on the 16th FETCH cycle -> DECODE
    ifu_rvalid = 1'b0;
    step(15);
    check("t3_still_fetch", {31'd0, ifu_req}, 32'd1);
    check("t3_no_err", {31'd0, err}, 32'd0);
    ifu_rvalid  = 1'b1;
    ifu_inst    = 32'h1000_006F;
    jump_valid  = 1'b1;
    jump_target = 32'h8000_0100;
    exu_waddr   = 5'd3;
    exu_wdata   = 32'h8000_000C;
    step();
    check("t3_decode_err", {31'd0, err}, 32'd0);
    check("t3_inst", inst, 32'h1000_006F);
    // 4a: aligned jump
    step(2);
    check("t4_wen_wb", {31'd0, rf_wen}, 32'd1);
    check("t4_wdata", rf_wdata, 32'h8000_000C);
    step();
    check("t4_jump_pc", ifu_pc, 32'h8000_0100);
    check("t4_ret", retired, 32'd3);

    // 3b: no rvalid for 16 cycles -> ERROR
    ifu_rvalid = 1'b0;
    jump_valid = 1'b0;
    step(15);
    check("t3_pre_err", {31'd0, err}, 32'd0);
    step();
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_err_req", {31'd0, ifu_req}, 32'd0);
    ifu_rvalid = 1'b1;
    step(3);
    check("t3_err_sticky", {31'd0, err}, 32'd1);
    check("t3_err_nowen", {31'd0, rf_wen}, 32'd0);
    do_reset();
    check("t3_rst_err", {31'd0, err}, 32'd0);

    // 4b: misaligned jump target
    jump_valid  = 1'b1;
    jump_target = 32'h8000_0102;
    step(3);
    check("t4_mis_err", {31'd0, err}, 32'd1);
    check("t4_mis_wen", {31'd0, rf_wen}, 32'd0);
    check("t4_mis_pc", ifu_pc, 32'h8000_0000);
    check("t4_mis_ret", retired, 32'd0);
    jump_valid = 1'b0;
    do_reset();

    // 5: ebreak
    is_ebreak = 1'b1;
    step(2);
    check("t5_pre_halt", {31'd0, halt}, 32'd0);
    step();
    check("t5_halt", {31'd0, halt}, 32'd1);
    check("t5_wen", {31'd0, rf_wen}, 32'd0);
    check("t5_req", {31'd0, ifu_req}, 32'd0);
    check("t5_ret", retired, 32'd0);
    step(2);
    check("t5_halt_sticky", {31'd0, halt}, 32'd1);
    check("t5_pc", ifu_pc, 32'h8000_0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_halt", {31'd0, halt}, 32'd0);
    check("t5_rst_pc", ifu_pc, 32'h8000_0000);
    is_ebreak = 1'b0;

    // 6: write to x0 suppressed, pc advances
    exu_wen   = 1'b1;
    exu_waddr = 5'd0;
    exu_wdata = 32'd99;
    step(3);
    check("t6_x0_wen", {31'd0, rf_wen}, 32'd0);
    step();
    check("t6_pc", ifu_pc, 32'h8000_0004);
    check("t6_ret", retired, 32'd1);

    // 6b: reset during DECODE aborts the instruction
    exu_waddr = 5'd4;
    step();
    check("t6_in_decode", {31'd0, ifu_req}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifu_rvalid = 1'b0;
    check("t6_rst_pc", ifu_pc, 32'h8000_0000);
    check("t6_rst_req", {31'd0, ifu_req}, 32'd1);
    check("t6_rst_ret", retired, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_wen", {31'd0, rf_wen}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
